// File: rtl/fc_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fc_stream_ctrl                                               |
// | Description : Sequencer for one fully-connected layer. For each neuron n   |
// |               it reads the bias word, streams NUM_IN node/weight pairs     |
// |               from single-port buffers into an external MAC core, waits    |
// |               for NUM_IN core results and publishes the last sum as the    |
// |               neuron output.                                               |
// | Ports       : clk, reset_n (async, active-low)                             |
// |               i_start / o_busy / o_done       - job control                |
// |               o_node_* / o_wegt_* / o_bias_*   - buffer read ports         |
// |               i_*_q                           - buffer data, 1-cycle lat.  |
// |               o_run, o_valid, o_node/wegt/bias - MAC core drive            |
// |               i_core_valid, i_core_result     - MAC core return            |
// |               o_res_valid, o_res_idx, o_res   - per-neuron result          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fc_stream_ctrl #(
  parameter int IN_DATA_WIDTH = 9,
  parameter int NUM_IN        = 16,
  parameter int NUM_OUT       = 4,
  parameter int AW_IN         = $clog2(NUM_IN),
  parameter int AW_W          = $clog2(NUM_IN * NUM_OUT),
  parameter int AW_OUT        = $clog2(NUM_OUT)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [AW_IN-1:0]                o_node_addr,
  output logic                            o_node_ce,
  input  logic [IN_DATA_WIDTH-1:0]        i_node_q,
  output logic [AW_W-1:0]                 o_wegt_addr,
  output logic                            o_wegt_ce,
  input  logic [IN_DATA_WIDTH-1:0]        i_wegt_q,
  output logic [AW_OUT-1:0]               o_bias_addr,
  output logic                            o_bias_ce,
  input  logic [IN_DATA_WIDTH-1:0]        i_bias_q,
  output logic                            o_run,
  output logic                            o_valid,
  output logic signed [IN_DATA_WIDTH-1:0] o_node,
  output logic signed [IN_DATA_WIDTH-1:0] o_wegt,
  output logic signed [IN_DATA_WIDTH-1:0] o_bias,
  input  logic                            i_core_valid,
  input  logic signed [4*IN_DATA_WIDTH-1:0] i_core_result,
  output logic                            o_res_valid,
  output logic [AW_OUT-1:0]               o_res_idx,
  output logic signed [4*IN_DATA_WIDTH-1:0] o_res
);

  // Return counter must be able to hold NUM_IN itself.
  localparam int c_cnt_w = $clog2(NUM_IN + 1);
  localparam logic [AW_IN-1:0]   c_k_last   = AW_IN'(NUM_IN - 1);
  localparam logic [c_cnt_w-1:0] c_c_last   = c_cnt_w'(NUM_IN - 1);
  localparam logic [AW_OUT-1:0]  c_n_last   = AW_OUT'(NUM_OUT - 1);
  localparam logic [AW_W-1:0]    c_num_in_w = AW_W'(NUM_IN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  logic [AW_OUT-1:0]  r_n;
  logic [AW_IN-1:0]   r_k;
  logic [c_cnt_w-1:0] r_c;
  logic [AW_W-1:0]    w_wegt_base;

  // Buffer data arrives in the same cycle as o_valid, so it is forwarded as-is.
  assign o_node = i_node_q;
  assign o_wegt = i_wegt_q;

  // First weight address of the current neuron's row.
  assign w_wegt_base = AW_W'(r_n) * c_num_in_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_k         <= '0;
      r_c         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_run       <= 1'b0;
      o_valid     <= 1'b0;
      o_node_ce   <= 1'b0;
      o_wegt_ce   <= 1'b0;
      o_bias_ce   <= 1'b0;
      o_node_addr <= '0;
      o_wegt_addr <= '0;
      o_bias_addr <= '0;
      o_bias      <= '0;
      o_res_valid <= 1'b0;
      o_res_idx   <= '0;
      o_res       <= '0;
    end else begin
      // Pulse-type outputs default low; each state re-asserts what it needs
      // for the following cycle.
      o_run       <= 1'b0;
      o_bias_ce   <= 1'b0;
      o_node_ce   <= 1'b0;
      o_wegt_ce   <= 1'b0;
      o_res_valid <= 1'b0;
      o_done      <= 1'b0;
      o_bias      <= '0;
      o_valid     <= o_node_ce;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_RUN;
            r_n         <= '0;
            r_k         <= '0;
            o_busy      <= 1'b1;
            o_run       <= 1'b1;
            o_bias_ce   <= 1'b1;
            o_bias_addr <= '0;
          end
        end

        S_RUN: begin
          r_state     <= S_FEED;
          r_k         <= '0;
          r_c         <= '0;
          o_node_ce   <= 1'b1;
          o_wegt_ce   <= 1'b1;
          o_node_addr <= '0;
          o_wegt_addr <= w_wegt_base;
        end

        S_FEED, S_DRAIN: begin
          if (r_state == S_FEED) begin
            // Bias read issued in RUN lands now; present it alongside the
            // first node/weight pair only so it is summed exactly once.
            if (r_k == '0) begin
              o_bias <= i_bias_q;
            end
            if (r_k == c_k_last) begin
              r_state <= S_DRAIN;
              r_k     <= '0;
            end else begin
              r_k         <= r_k + AW_IN'(1);
              o_node_ce   <= 1'b1;
              o_wegt_ce   <= 1'b1;
              o_node_addr <= r_k + AW_IN'(1);
              o_wegt_addr <= o_wegt_addr + AW_W'(1);
            end
          end
          if (i_core_valid) begin
            r_c <= r_c + c_cnt_w'(1);
            // The NUM_IN-th core return carries the complete sum.
            if (r_c == c_c_last) begin
              o_res       <= i_core_result;
              o_res_valid <= 1'b1;
              o_res_idx   <= r_n;
              r_state     <= S_WRITE;
              r_k         <= '0;
              o_node_ce   <= 1'b0;
              o_wegt_ce   <= 1'b0;
            end
          end
        end

        S_WRITE: begin
          if (r_n == c_n_last) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end else begin
            r_n         <= r_n + AW_OUT'(1);
            r_state     <= S_RUN;
            o_run       <= 1'b1;
            o_bias_ce   <= 1'b1;
            o_bias_addr <= r_n + AW_OUT'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_n     <= '0;
          o_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fc_stream_ctrl                                            |
// | Description : Self-checking bench for fc_stream_ctrl. Provides node,       |
// |               weight and bias buffers with one-cycle read latency and a    |
// |               one-cycle MAC core; expected sums come from a dot-product    |
// |               reference over the buffer contents.                          |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fc_stream_ctrl;

  localparam int W  = 9;
  localparam int NI = 16;
  localparam int NO = 4;
  localparam int RW = 4 * W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_start = 1'b0;
  logic              o_busy, o_done;
  logic [3:0]        o_node_addr;
  logic              o_node_ce;
  logic [W-1:0]      node_q;
  logic [5:0]        o_wegt_addr;
  logic              o_wegt_ce;
  logic [W-1:0]      wegt_q;
  logic [1:0]        o_bias_addr;
  logic              o_bias_ce;
  logic [W-1:0]      bias_q;
  logic              o_run, o_valid;
  logic signed [W-1:0] o_node, o_wegt, o_bias;
  logic              core_valid;
  logic [RW-1:0]     core_result;
  logic              o_res_valid;
  logic [1:0]        o_res_idx;
  logic signed [RW-1:0] o_res;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_stream_ctrl #(
    .IN_DATA_WIDTH(W), .NUM_IN(NI), .NUM_OUT(NO),
    .AW_IN(4), .AW_W(6), .AW_OUT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done),
    .o_node_addr(o_node_addr), .o_node_ce(o_node_ce), .i_node_q(node_q),
    .o_wegt_addr(o_wegt_addr), .o_wegt_ce(o_wegt_ce), .i_wegt_q(wegt_q),
    .o_bias_addr(o_bias_addr), .o_bias_ce(o_bias_ce), .i_bias_q(bias_q),
    .o_run(o_run), .o_valid(o_valid),
    .o_node(o_node), .o_wegt(o_wegt), .o_bias(o_bias),
    .i_core_valid(core_valid), .i_core_result(core_result),
    .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res(o_res)
  );

  // Buffers: one-cycle read latency.
  logic [W-1:0] node_mem [NI];
  logic [W-1:0] wegt_mem [NI*NO];
  logic [W-1:0] bias_mem [NO];

  always @(posedge clk) begin
    if (o_node_ce) node_q <= node_mem[o_node_addr];
    if (o_wegt_ce) wegt_q <= wegt_mem[o_wegt_addr];
    if (o_bias_ce) bias_q <= bias_mem[o_bias_addr];
  end

  // MAC core: o_run clears, each o_valid adds node*weight+bias, result and
  // valid appear one cycle later.
  longint acc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= 0;
      core_valid <= 1'b0;
    end else begin
      core_valid <= o_valid;
      if (o_run) acc <= 0;
      else if (o_valid)
        acc <= acc + longint'(o_node) * longint'(o_wegt) + longint'(o_bias);
    end
  end
  assign core_result = acc[RW-1:0];

  // Reference: dot product of row n plus bias n.
  function automatic longint model_res(input int n);
    longint s;
    s = longint'($signed(bias_mem[n]));
    for (int k = 0; k < NI; k++)
      s += longint'($signed(node_mem[k])) * longint'($signed(wegt_mem[n*NI+k]));
    return s;
  endfunction

  function automatic logic [66:0] outs_vec();
    return {o_busy, o_done, o_run, o_valid, o_node_ce, o_wegt_ce, o_bias_ce,
            o_node_addr, o_wegt_addr, o_bias_addr, o_bias, o_res_valid,
            o_res_idx, o_res};
  endfunction

  // Observations of the most recent job.
  int           ev_rel[$];
  int           ev_idx[$];
  logic [RW-1:0] ev_res[$];
  int           done_rel[$];
  logic [W-1:0] first_bias[$];
  int           bias_viol, run_cnt, run_valid_viol;
  logic         busy_at1, busy_end;
  logic [66:0]  rst_snap;

  task automatic load_fill(input int nv, input int wv, input int bv, input bit w_by_idx);
    for (int k = 0; k < NI; k++) node_mem[k] = W'(nv);
    for (int a = 0; a < NI*NO; a++) wegt_mem[a] = w_by_idx ? W'(a / NI + 1) : W'(wv);
    for (int n = 0; n < NO; n++) bias_mem[n] = W'(bv);
  endtask

  task automatic load_random();
    for (int k = 0; k < NI; k++) node_mem[k] = W'($urandom_range(0, 511));
    for (int a = 0; a < NI*NO; a++) wegt_mem[a] = W'($urandom_range(0, 511));
    for (int n = 0; n < NO; n++) bias_mem[n] = W'($urandom_range(0, 511));
  endtask

  // Start a job at relative cycle 0 and observe ncyc cycles. Extra start
  // pulses at p1/p2, and reset_n held low during cycles rst_at..rst_at+1.
  task automatic run_job(input int p1, input int p2, input int rst_at, input int ncyc);
    int t0;
    bit first;
    ev_rel.delete(); ev_idx.delete(); ev_res.delete();
    done_rel.delete(); first_bias.delete();
    bias_viol = 0; run_cnt = 0; run_valid_viol = 0; first = 0;
    rst_snap = '1;
    @(negedge clk);
    i_start = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel <= ncyc; rel++) begin
      @(negedge clk);
      if (cyc - t0 != rel) $fatal(1, "FAIL bench_cycle_sync got %0d expected %0d", cyc - t0, rel);
      if (rel == 1) busy_at1 = o_busy;
      if (o_res_valid) begin
        ev_rel.push_back(rel); ev_idx.push_back(int'(o_res_idx)); ev_res.push_back(o_res);
      end
      if (o_done) done_rel.push_back(rel);
      if (o_run) begin
        run_cnt++;
        if (o_valid) run_valid_viol++;
        first = 1;
      end
      if (o_valid) begin
        if (first) begin first_bias.push_back(o_bias); first = 0; end
        else if (o_bias != 0) bias_viol++;
      end
      if (rst_at >= 0 && rel == rst_at + 1) rst_snap = outs_vec();
      i_start = (rel == p1 || rel == p2);
      if (rst_at >= 0) reset_n = !(rel == rst_at || rel == rst_at + 1);
    end
    busy_end = o_busy;
  endtask

  task automatic test_reset();
    logic [66:0] v;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    v = outs_vec();
    cmp_cnt++;
    if (v !== '0) begin err_cnt++; $display("FAIL reset_outputs got %h expected 0", v); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    v = outs_vec();
    cmp_cnt++;
    if (v !== '0) begin err_cnt++; $display("FAIL idle_outputs got %h expected 0", v); end
  endtask

  // Constant patterns with hand-computed sums.
  task automatic test_fixed_patterns();
    int exp_tab [3][4] = '{'{35, 35, 35, 35}, '{-101, -101, -101, -101}, '{16, 32, 48, 64}};
    logic [RW-1:0] e;
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: load_fill(1, 2, 3, 1'b0);
        1: load_fill(3, -2, -5, 1'b0);
        default: load_fill(1, 0, 0, 1'b1);
      endcase
      run_job(-1, -1, -1, 90);
      cmp_cnt++;
      if (busy_at1 !== 1'b1) begin err_cnt++; $display("FAIL p%0d busy_in_run got %b expected 1", p, busy_at1); end
      cmp_cnt++;
      if (ev_rel.size() != NO) begin err_cnt++; $display("FAIL p%0d res_count got %0d expected %0d", p, ev_rel.size(), NO); end
      for (int i = 0; i < ev_rel.size() && i < NO; i++) begin
        e = RW'(exp_tab[p][i]);
        cmp_cnt++;
        if (ev_res[i] !== e) begin err_cnt++; $display("FAIL p%0d res[%0d] got %0d expected %0d", p, i, $signed(ev_res[i]), $signed(e)); end
        cmp_cnt++;
        if (ev_idx[i] != i) begin err_cnt++; $display("FAIL p%0d res_idx[%0d] got %0d expected %0d", p, i, ev_idx[i], i); end
        cmp_cnt++;
        if (ev_rel[i] != 20 * (i + 1)) begin err_cnt++; $display("FAIL p%0d res_cycle[%0d] got %0d expected %0d", p, i, ev_rel[i], 20 * (i + 1)); end
      end
      cmp_cnt++;
      if (done_rel.size() != 1 || done_rel[0] != 81) begin
        err_cnt++; $display("FAIL p%0d done got count %0d first %0d expected one at 81", p, done_rel.size(), (done_rel.size() > 0) ? done_rel[0] : -1);
      end
      cmp_cnt++;
      if (busy_end !== 1'b0) begin err_cnt++; $display("FAIL p%0d busy_after_done got %b expected 0", p, busy_end); end
      cmp_cnt++;
      if (run_cnt != NO || run_valid_viol != 0) begin
        err_cnt++; $display("FAIL p%0d run_pulses got %0d (with valid %0d) expected %0d (0)", p, run_cnt, run_valid_viol, NO);
      end
    end
  endtask

  task automatic test_random();
    longint m;
    for (int it = 0; it < 3; it++) begin
      load_random();
      run_job(-1, -1, -1, 88);
      cmp_cnt++;
      if (ev_rel.size() != NO) begin err_cnt++; $display("FAIL rnd%0d res_count got %0d expected %0d", it, ev_rel.size(), NO); end
      for (int i = 0; i < ev_rel.size() && i < NO; i++) begin
        m = model_res(i);
        cmp_cnt++;
        if (ev_res[i] !== m[RW-1:0] || ev_idx[i] != i || ev_rel[i] != 20 * (i + 1)) begin
          err_cnt++;
          $display("FAIL rnd%0d res[%0d] got %0d idx %0d cyc %0d expected %0d idx %0d cyc %0d",
                   it, i, $signed(ev_res[i]), ev_idx[i], ev_rel[i], m, i, 20 * (i + 1));
        end
      end
      cmp_cnt++;
      if (first_bias.size() != NO) begin err_cnt++; $display("FAIL rnd%0d first_bias_count got %0d expected %0d", it, first_bias.size(), NO); end
      for (int i = 0; i < first_bias.size() && i < NO; i++) begin
        cmp_cnt++;
        if (first_bias[i] !== bias_mem[i]) begin err_cnt++; $display("FAIL rnd%0d first_bias[%0d] got %h expected %h", it, i, first_bias[i], bias_mem[i]); end
      end
      cmp_cnt++;
      if (bias_viol != 0) begin err_cnt++; $display("FAIL rnd%0d bias_outside_first got %0d expected 0", it, bias_viol); end
      cmp_cnt++;
      if (run_cnt != NO || run_valid_viol != 0) begin
        err_cnt++; $display("FAIL rnd%0d run_pulses got %0d (with valid %0d) expected %0d (0)", it, run_cnt, run_valid_viol, NO);
      end
    end
  endtask

  task automatic test_start_ignored();
    load_random();
    run_job(5, 30, -1, 100);
    cmp_cnt++;
    if (ev_rel.size() != NO) begin err_cnt++; $display("FAIL start_ign res_count got %0d expected %0d", ev_rel.size(), NO); end
    cmp_cnt++;
    if (done_rel.size() != 1 || done_rel[0] != 81) begin
      err_cnt++; $display("FAIL start_ign done got count %0d first %0d expected one at 81", done_rel.size(), (done_rel.size() > 0) ? done_rel[0] : -1);
    end
    for (int i = 0; i < ev_rel.size() && i < NO; i++) begin
      cmp_cnt++;
      if (ev_rel[i] != 20 * (i + 1)) begin err_cnt++; $display("FAIL start_ign res_cycle[%0d] got %0d expected %0d", i, ev_rel[i], 20 * (i + 1)); end
    end
    cmp_cnt++;
    if (busy_end !== 1'b0) begin err_cnt++; $display("FAIL start_ign busy_end got %b expected 0", busy_end); end
  endtask

  task automatic test_reset_abort();
    longint m;
    load_random();
    run_job(15, -1, 10, 110);
    cmp_cnt++;
    if (rst_snap !== '0) begin err_cnt++; $display("FAIL abort_outputs got %h expected 0", rst_snap); end
    cmp_cnt++;
    if (ev_rel.size() != NO) begin err_cnt++; $display("FAIL abort res_count got %0d expected %0d", ev_rel.size(), NO); end
    for (int i = 0; i < ev_rel.size() && i < NO; i++) begin
      m = model_res(i);
      cmp_cnt++;
      if (ev_rel[i] != 35 + 20 * i || ev_idx[i] != i || ev_res[i] !== m[RW-1:0]) begin
        err_cnt++;
        $display("FAIL abort res[%0d] got cyc %0d idx %0d val %0d expected cyc %0d idx %0d val %0d",
                 i, ev_rel[i], ev_idx[i], $signed(ev_res[i]), 35 + 20 * i, i, m);
      end
    end
    cmp_cnt++;
    if (done_rel.size() != 1 || done_rel[0] != 96) begin
      err_cnt++; $display("FAIL abort done got count %0d first %0d expected one at 96", done_rel.size(), (done_rel.size() > 0) ? done_rel[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_patterns();
    test_random();
    test_start_ignored();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_stream_ctrl.md
FC_STREAM_CTRL -- requirements
Module: fc_stream_ctrl

Interface
REQ-001 Parameters SHALL be IN_DATA_WIDTH, default 9, width of node, weight and bias words.
REQ-002 Parameters SHALL be NUM_IN, default 16, input vector length (elements per neuron).
REQ-003 Parameters SHALL be NUM_OUT, default 4, neuron count; AW_IN=4, AW_W=6, AW_OUT=2 are address widths (clog2 of NUM_IN, NUM_IN*NUM_OUT, NUM_OUT).
REQ-004 Ports SHALL be, clock and reset first: clk in 1 clock; reset_n in 1 reset, asynchronous, active-low.
REQ-005 Control ports SHALL be: i_start in 1 start pulse; o_busy out 1 high outside IDLE; o_done out 1 one-cycle completion pulse.
REQ-006 Node buffer ports SHALL be: o_node_addr out AW_IN; o_node_ce out 1; i_node_q in IN_DATA_WIDTH, read data one cycle after ce.
REQ-007 Weight buffer ports SHALL be: o_wegt_addr out AW_W; o_wegt_ce out 1; i_wegt_q in IN_DATA_WIDTH, one-cycle read latency.
REQ-008 Bias buffer ports SHALL be: o_bias_addr out AW_OUT; o_bias_ce out 1; i_bias_q in IN_DATA_WIDTH, one-cycle read latency.
REQ-009 MAC-core drive ports SHALL be: o_run out 1 accumulator clear; o_valid out 1; o_node, o_wegt, o_bias out IN_DATA_WIDTH each, signed.
REQ-010 MAC-core return ports SHALL be: i_core_valid in 1; i_core_result in 4*IN_DATA_WIDTH, signed accumulated sum.
REQ-011 Result ports SHALL be: o_res_valid out 1; o_res_idx out AW_OUT neuron index; o_res out 4*IN_DATA_WIDTH signed.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FEED, DRAIN, WRITE, DONE; each state lasts whole cycles, transitions at clk rising edge.
REQ-013 IDLE -> RUN when i_start=1; i_start in any other state SHALL be ignored.
REQ-014 RUN SHALL last 1 cycle: o_run=1, o_valid=0, o_bias_ce=1, o_bias_addr=n (current neuron); then -> FEED with element counter k=0 and return counter c=0.
REQ-015 FEED SHALL last exactly NUM_IN cycles: o_node_ce=o_wegt_ce=1, o_node_addr=k, o_wegt_addr=n*NUM_IN+k, k increments by 1 each cycle; -> DRAIN after k=NUM_IN-1.
REQ-016 o_valid SHALL equal o_node_ce delayed one cycle; o_node=i_node_q and o_wegt=i_wegt_q, passed through unregistered.
REQ-017 Bias word SHALL be captured from i_bias_q in the first FEED cycle; o_bias SHALL equal that word on the first o_valid cycle of a neuron and 0 on all others, so bias enters the sum exactly once.
REQ-018 Counter c SHALL increment on each i_core_valid=1 cycle after RUN; the cycle c reaches NUM_IN, i_core_result SHALL be captured unchanged into o_res, and the FSM SHALL go from DRAIN (or FEED) to WRITE.
REQ-019 WRITE SHALL last 1 cycle with o_res_valid=1, o_res_idx=n; then -> RUN with n+1 if n<NUM_OUT-1, else -> DONE.
REQ-020 DONE SHALL last 1 cycle with o_done=1, then -> IDLE with n=0.
REQ-021 Timing with start sampled at cycle 0: RUN cycle 1, FEED cycles 2..NUM_IN+1, o_valid cycles 3..NUM_IN+2, WRITE cycle NUM_IN+4; neuron period SHALL be NUM_IN+4 cycles.
REQ-022 o_res SHALL hold its last captured value between WRITE cycles; all read enables SHALL be 0 outside RUN/FEED.
REQ-023 i_core_valid outside FEED/DRAIN SHALL be ignored and SHALL NOT change c.

Reset
REQ-024 reset_n=0 SHALL asynchronously force IDLE, n=k=c=0, and all outputs to 0 (o_busy, o_done, o_run, o_valid, all ce, addresses, o_bias, o_res_valid, o_res_idx, o_res).
REQ-025 Reset asserted mid-operation SHALL abort without any further o_res_valid or o_done; a following i_start SHALL restart from neuron 0.

Verification
REQ-026 All nodes=1, all weights=2, all biases=3, start -> o_res=35 at idx 0..3, o_res_valid cycles 20,40,60,80, o_done cycle 81.
REQ-027 Nodes=3, weights=-2 (9'h1FE), bias=-5 -> o_res=-101 sign-extended to 36 bits for every neuron.
REQ-028 Weights = neuron index+1, nodes=1, bias=0 -> o_res=16,32,48,64 in idx order; verifies o_wegt_addr=n*16+k.
REQ-029 i_start pulsed at cycles 5 and 30 during run -> exactly 4 o_res_valid and one o_done; second start ignored.
REQ-030 reset_n low at cycle 10 (mid-FEED) -> all outputs 0 next cycle, no result emitted; start at cycle 15 -> first o_res_valid at cycle 35.
REQ-031 o_bias checked each o_valid cycle -> nonzero only on first element per neuron; o_run high exactly once per neuron, always with o_valid=0.
